// File: rtl/rv32i_pkg.sv
// Shared RV32I types: ALU op codes, operand selects, datapath widths.
package rv32i_pkg;

   localparam int XLEN = 32;
   localparam int REGW = 5;

   typedef enum logic [4:0] {
      ALU_ADD  = 5'b00000,
      ALU_SUB  = 5'b00001,
      ALU_AND  = 5'b00010,
      ALU_OR   = 5'b00011,
      ALU_XOR  = 5'b00100,
      ALU_SLT  = 5'b00101,
      ALU_SLL  = 5'b00110,
      ALU_SRL  = 5'b00111,
      ALU_SRA  = 5'b01000,
      ALU_SLTU = 5'b01001
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      OPA_RS1  = 2'd0,
      OPA_PC   = 2'd1,
      OPA_ZERO = 2'd2,
      OPA_RSV  = 2'd3
   } opa_sel_t;

   typedef enum logic {
      OPB_RS2 = 1'b0,
      OPB_IMM = 1'b1
   } opb_sel_t;

endpackage

// File: rtl/fwd_unit.sv
// Per-source forward select and RAW hazard detection for ID/EX.
// ID_EX_FWD_EN selects forwarding; otherwise any pending write stalls.
module fwd_unit #(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            i_ex_valid,
   input  logic            i_ex_reg_write,
   input  logic            i_ex_is_load,
   input  logic [REGW-1:0] i_ex_rd,
   input  logic [XLEN-1:0] i_ex_result,
   input  logic            i_mem_reg_write,
   input  logic            i_mem_is_load,
   input  logic [REGW-1:0] i_mem_rd,
   input  logic [XLEN-1:0] i_mem_result,
   input  logic            i_wb_reg_write,
   input  logic [REGW-1:0] i_wb_rd,
   input  logic [XLEN-1:0] i_wb_data,
   input  logic [REGW-1:0] i_rs1,
   input  logic [REGW-1:0] i_rs2,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   input  logic            i_use1,
   input  logic            i_use2,
   output logic [XLEN-1:0] o_rs1_val,
   output logic [XLEN-1:0] o_rs2_val,
   output logic            o_hazard
);
   import rv32i_pkg::*;

`ifdef ID_EX_FWD_EN
   function automatic logic [XLEN-1:0] f_fwd(
      input logic [REGW-1:0] rs,
      input logic [XLEN-1:0] rf
   );
      logic [XLEN-1:0] v;
      v = rf;
      if (rs == '0)
         v = '0;
      else if (i_ex_valid && i_ex_reg_write &&
               !i_ex_is_load && i_ex_rd == rs)
         v = i_ex_result;
      else if (i_mem_reg_write && !i_mem_is_load &&
               i_mem_rd == rs)
         v = i_mem_result;
      else if (i_wb_reg_write && i_wb_rd == rs)
         v = i_wb_data;
      return v;
   endfunction

   // Only loads stall: their data is not yet forwardable.
   function automatic logic f_stall(
      input logic [REGW-1:0] rs,
      input logic            used
   );
      logic ex_hit;
      logic mem_hit;
      ex_hit  = i_ex_valid && i_ex_reg_write &&
                i_ex_is_load && i_ex_rd == rs;
      mem_hit = i_mem_reg_write && i_mem_is_load &&
                i_mem_rd == rs;
      return used && (rs != '0) && (ex_hit || mem_hit);
   endfunction

   logic w_unused;
   assign w_unused = 1'b0;
`else
   function automatic logic [XLEN-1:0] f_fwd(
      input logic [REGW-1:0] rs,
      input logic [XLEN-1:0] rf
   );
      return (rs == '0) ? '0 : rf;
   endfunction

   // Without bypass paths, wait until the write reaches the register file.
   function automatic logic f_stall(
      input logic [REGW-1:0] rs,
      input logic            used
   );
      logic ex_hit;
      logic mem_hit;
      logic wb_hit;
      ex_hit  = i_ex_valid && i_ex_reg_write && i_ex_rd == rs;
      mem_hit = i_mem_reg_write && i_mem_rd == rs;
      wb_hit  = i_wb_reg_write && i_wb_rd == rs;
      return used && (rs != '0) && (ex_hit || mem_hit || wb_hit);
   endfunction

   logic w_unused;
   assign w_unused = ^{i_ex_is_load, i_ex_result, i_mem_is_load,
                       i_mem_result, i_wb_data};
`endif

   assign o_rs1_val = f_fwd(i_rs1, i_rs1_data);
   assign o_rs2_val = f_fwd(i_rs2, i_rs2_data);
   assign o_hazard  = f_stall(i_rs1, i_use1) || f_stall(i_rs2, i_use2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand select, forwarding and stall.
// Define ID_EX_FWD_EN to enable the EX/MEM/WB bypass network.
module id_ex_stage #(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            dec_valid,
   output logic            dec_ready,
   input  logic [XLEN-1:0] dec_pc,
   input  logic [REGW-1:0] dec_rs1,
   input  logic [REGW-1:0] dec_rs2,
   input  logic [XLEN-1:0] dec_rs1_data,
   input  logic [XLEN-1:0] dec_rs2_data,
   input  logic [XLEN-1:0] dec_imm,
   input  logic [1:0]      dec_opa_sel,
   input  logic            dec_opb_sel,
   input  logic [4:0]      dec_alu_ctrl,
   input  logic [REGW-1:0] dec_rd,
   input  logic            dec_reg_write,
   input  logic            dec_is_load,
   input  logic [XLEN-1:0] ex_result,
   input  logic [REGW-1:0] mem_rd,
   input  logic [REGW-1:0] wb_rd,
   input  logic            mem_reg_write,
   input  logic            wb_reg_write,
   input  logic            mem_is_load,
   input  logic [XLEN-1:0] mem_result,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] a_in,
   output logic [XLEN-1:0] b_in,
   output logic [4:0]      ALUControl,
   output logic [REGW-1:0] ex_rd,
   output logic            ex_reg_write,
   output logic            ex_is_load,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs2_val
);
   import rv32i_pkg::*;

   logic            r_valid;
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_b;
   logic [4:0]      r_alu;
   logic [REGW-1:0] r_rd;
   logic            r_rw;
   logic            r_ld;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_rs2v;

   logic            w_adv;
   logic            w_hazard;
   logic            w_capture;
   logic            w_use1;
   logic            w_use2;
   logic [XLEN-1:0] w_rs1_val;
   logic [XLEN-1:0] w_rs2_val;
   logic [XLEN-1:0] w_a_nxt;
   logic [XLEN-1:0] w_b_nxt;

   // Stores read rs2 for the write data even with an immediate operand B.
   assign w_use1 = (dec_opa_sel == OPA_RS1);
   assign w_use2 = (dec_opb_sel == OPB_RS2) ||
                   (!dec_reg_write && !dec_is_load);

   fwd_unit #(
      .XLEN(XLEN),
      .REGW(REGW)
   ) u_fwd (
      .i_ex_valid      (r_valid),
      .i_ex_reg_write  (r_rw),
      .i_ex_is_load    (r_ld),
      .i_ex_rd         (r_rd),
      .i_ex_result     (ex_result),
      .i_mem_reg_write (mem_reg_write),
      .i_mem_is_load   (mem_is_load),
      .i_mem_rd        (mem_rd),
      .i_mem_result    (mem_result),
      .i_wb_reg_write  (wb_reg_write),
      .i_wb_rd         (wb_rd),
      .i_wb_data       (wb_data),
      .i_rs1           (dec_rs1),
      .i_rs2           (dec_rs2),
      .i_rs1_data      (dec_rs1_data),
      .i_rs2_data      (dec_rs2_data),
      .i_use1          (w_use1),
      .i_use2          (w_use2),
      .o_rs1_val       (w_rs1_val),
      .o_rs2_val       (w_rs2_val),
      .o_hazard        (w_hazard)
   );

   assign w_adv     = !r_valid || ex_ready;
   assign dec_ready = w_adv && !w_hazard && !flush;
   assign w_capture = dec_valid && dec_ready;

   always_comb begin
      w_a_nxt = '0;
      unique case (1'b1)
         (dec_opa_sel == OPA_RS1): w_a_nxt = w_rs1_val;
         (dec_opa_sel == OPA_PC):  w_a_nxt = dec_pc;
         default:                  w_a_nxt = '0;
      endcase
   end

   assign w_b_nxt = (dec_opb_sel == OPB_IMM) ? dec_imm : w_rs2_val;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_alu   <= ALU_ADD;
         r_rd    <= '0;
         r_rw    <= 1'b0;
         r_ld    <= 1'b0;
         r_pc    <= '0;
         r_rs2v  <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_capture) begin
         r_valid <= 1'b1;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_alu   <= dec_alu_ctrl;
         r_rd    <= dec_rd;
         r_rw    <= dec_reg_write;
         r_ld    <= dec_is_load;
         r_pc    <= dec_pc;
         r_rs2v  <= w_rs2_val;
      end else if (w_adv) begin
         r_valid <= 1'b0;
      end
   end

   assign ex_valid     = r_valid;
   assign a_in         = r_a;
   assign b_in         = r_b;
   assign ALUControl   = r_alu;
   assign ex_rd        = r_rd;
   assign ex_reg_write = r_rw;
   assign ex_is_load   = r_ld;
   assign ex_pc        = r_pc;
   assign ex_rs2_val   = r_rs2v;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (both ID_EX_FWD_EN builds).
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_pc;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [31:0] dec_rs1_data;
   logic [31:0] dec_rs2_data;
   logic [31:0] dec_imm;
   logic [1:0]  dec_opa_sel;
   logic        dec_opb_sel;
   logic [4:0]  dec_alu_ctrl;
   logic [4:0]  dec_rd;
   logic        dec_reg_write;
   logic        dec_is_load;
   logic [31:0] ex_result;
   logic [4:0]  mem_rd;
   logic [4:0]  wb_rd;
   logic        mem_reg_write;
   logic        wb_reg_write;
   logic        mem_is_load;
   logic [31:0] mem_result;
   logic [31:0] wb_data;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic [4:0]  ALUControl;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_is_load;
   logic [31:0] ex_pc;
   logic [31:0] ex_rs2_val;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(reset),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_pc(dec_pc), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
      .dec_imm(dec_imm), .dec_opa_sel(dec_opa_sel),
      .dec_opb_sel(dec_opb_sel), .dec_alu_ctrl(dec_alu_ctrl),
      .dec_rd(dec_rd), .dec_reg_write(dec_reg_write),
      .dec_is_load(dec_is_load), .ex_result(ex_result),
      .mem_rd(mem_rd), .wb_rd(wb_rd),
      .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
      .mem_is_load(mem_is_load), .mem_result(mem_result),
      .wb_data(wb_data), .flush(flush),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .a_in(a_in), .b_in(b_in), .ALUControl(ALUControl),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_is_load(ex_is_load), .ex_pc(ex_pc),
      .ex_rs2_val(ex_rs2_val)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      dec_valid = 0; dec_pc = 0; dec_rs1 = 0; dec_rs2 = 0;
      dec_rs1_data = 0; dec_rs2_data = 0; dec_imm = 0;
      dec_opa_sel = 0; dec_opb_sel = 0; dec_alu_ctrl = 0;
      dec_rd = 0; dec_reg_write = 0; dec_is_load = 0;
      ex_result = 0; mem_rd = 0; wb_rd = 0;
      mem_reg_write = 0; wb_reg_write = 0; mem_is_load = 0;
      mem_result = 0; wb_data = 0; flush = 0; ex_ready = 1;
   endtask

   task automatic issue(
      input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] d1, input logic [31:0] d2,
      input logic [31:0] imm, input logic [31:0] pc,
      input logic [1:0] opa, input logic opb,
      input logic [4:0] alu, input logic [4:0] rd,
      input logic rw, input logic ld
   );
      dec_valid = 1; dec_rs1 = rs1; dec_rs2 = rs2;
      dec_rs1_data = d1; dec_rs2_data = d2; dec_imm = imm;
      dec_pc = pc; dec_opa_sel = opa; dec_opb_sel = opb;
      dec_alu_ctrl = alu; dec_rd = rd;
      dec_reg_write = rw; dec_is_load = ld;
   endtask

   task automatic test_reset;
      reset = 1; idle(); #3;
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", ex_valid); end
      total++; if (a_in !== 32'h0) begin bad++; $display("FAIL rst_a got=%0h exp=0", a_in); end
      total++; if (b_in !== 32'h0) begin bad++; $display("FAIL rst_b got=%0h exp=0", b_in); end
      total++; if (ALUControl !== 5'h0) begin bad++; $display("FAIL rst_alu got=%0h exp=0", ALUControl); end
      total++; if (ex_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%0h exp=0", ex_pc); end
      total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0h exp=1", dec_ready); end
      tick(); reset = 0; #1;
   endtask

   task automatic test_back_to_back;
      issue(0, 0, 32'hDEAD, 0, 5, 32'h100, 0, 1, 5'h00, 1, 1, 0); #1;
      total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL b2b_rdy0 got=%0h exp=1", dec_ready); end
      tick();
      total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL b2b_v0 got=%0h exp=1", ex_valid); end
      total++; if (a_in !== 32'h0) begin bad++; $display("FAIL b2b_a0 got=%0h exp=0", a_in); end
      total++; if (b_in !== 32'h5) begin bad++; $display("FAIL b2b_b0 got=%0h exp=5", b_in); end
      total++; if (ex_pc !== 32'h100) begin bad++; $display("FAIL b2b_pc0 got=%0h exp=100", ex_pc); end
      ex_result = 5;
      issue(1, 1, 32'h77, 32'h77, 0, 32'h104, 0, 0, 5'h00, 2, 1, 0); #1;
`ifdef ID_EX_FWD_EN
      total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL b2b_rdy1 got=%0h exp=1", dec_ready); end
      tick();
`else
      total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ex got=%0h exp=0", dec_ready); end
      tick();
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL b2b_bubble got=%0h exp=0", ex_valid); end
      mem_rd = 1; mem_reg_write = 1; mem_result = 5; #1;
      total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_mem got=%0h exp=0", dec_ready); end
      tick();
      mem_reg_write = 0; wb_rd = 1; wb_reg_write = 1; wb_data = 5; #1;
      total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_wb got=%0h exp=0", dec_ready); end
      tick();
      wb_reg_write = 0; dec_rs1_data = 5; dec_rs2_data = 5; #1;
      total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL b2b_clear got=%0h exp=1", dec_ready); end
      tick();
`endif
      total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL b2b_v1 got=%0h exp=1", ex_valid); end
      total++; if (a_in !== 32'h5) begin bad++; $display("FAIL b2b_a1 got=%0h exp=5", a_in); end
      total++; if (b_in !== 32'h5) begin bad++; $display("FAIL b2b_b1 got=%0h exp=5", b_in); end
      total++; if (ex_rd !== 5'd2) begin bad++; $display("FAIL b2b_rd1 got=%0h exp=2", ex_rd); end
      idle(); tick();
   endtask

   task automatic test_load_use;
      issue(0, 0, 0, 0, 32'h100, 32'h200, 0, 1, 5'h00, 3, 1, 1);
      tick();
      total++; if (ex_is_load !== 1'b1) begin bad++; $display("FAIL lu_isload got=%0h exp=1", ex_is_load); end
      ex_result = 32'h100;
      issue(3, 0, 32'h99, 32'h88, 0, 32'h204, 0, 0, 5'h00, 4, 1, 0); #1;
      total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL lu_stall got=%0h exp=0", dec_ready); end
      tick();
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%0h exp=0", ex_valid); end
      mem_rd = 3; mem_reg_write = 1; mem_is_load = 0; mem_result = 32'h1234;
`ifndef ID_EX_FWD_EN
      #1;
      total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL lu_stall_mem got=%0h exp=0", dec_ready); end
      tick();
      mem_reg_write = 0; dec_rs1_data = 32'h1234;
`endif
      #1;
      total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL lu_go got=%0h exp=1", dec_ready); end
      tick();
      total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL lu_v got=%0h exp=1", ex_valid); end
      total++; if (a_in !== 32'h1234) begin bad++; $display("FAIL lu_a got=%0h exp=1234", a_in); end
      total++; if (b_in !== 32'h0) begin bad++; $display("FAIL lu_b_x0 got=%0h exp=0", b_in); end
      idle(); tick();
      mem_rd = 6; mem_reg_write = 1; mem_is_load = 1;
      issue(6, 0, 0, 0, 4, 32'h300, 0, 1, 5'h00, 7, 1, 0); #1;
      total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL memld_stall got=%0h exp=0", dec_ready); end
      dec_opa_sel = 1; #1;
      total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL memld_unused got=%0h exp=1", dec_ready); end
      idle(); tick();
   endtask

   task automatic test_priority;
      issue(0, 0, 0, 0, 1, 32'h500, 0, 1, 5'h00, 5, 1, 0);
      tick();
      ex_result = 1;
      mem_rd = 5; mem_reg_write = 1; mem_result = 2;
      wb_rd = 5; wb_reg_write = 1; wb_data = 3;
      issue(5, 0, 32'h50, 0, 7, 32'h504, 0, 1, 5'h00, 6, 1, 0); #1;
`ifdef ID_EX_FWD_EN
      total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL pri_rdy got=%0h exp=1", dec_ready); end
      tick();
      total++; if (a_in !== 32'h1) begin bad++; $display("FAIL pri_ex got=%0h exp=1", a_in); end
      total++; if (b_in !== 32'h7) begin bad++; $display("FAIL pri_imm got=%0h exp=7", b_in); end
      ex_result = 32'h111; dec_rd = 8;
      tick();
      total++; if (a_in !== 32'h2) begin bad++; $display("FAIL pri_mem got=%0h exp=2", a_in); end
      mem_reg_write = 0;
      tick();
      total++; if (a_in !== 32'h3) begin bad++; $display("FAIL pri_wb got=%0h exp=3", a_in); end
      wb_reg_write = 0;
      tick();
      total++; if (a_in !== 32'h50) begin bad++; $display("FAIL pri_rf got=%0h exp=50", a_in); end
`else
      total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL pri_stall got=%0h exp=0", dec_ready); end
`endif
      idle(); tick();
   endtask

   task automatic test_x0;
      issue(0, 0, 0, 0, 32'hFFFF, 32'h600, 0, 1, 5'h00, 0, 1, 0);
      tick();
      ex_result = 32'hFFFF;
      mem_rd = 0; mem_reg_write = 1; mem_result = 32'hFFFF;
      wb_rd = 0; wb_reg_write = 1; wb_data = 32'hFFFF;
      issue(0, 0, 32'hABCD, 32'hABCD, 0, 32'h604, 0, 0, 5'h00, 9, 1, 0); #1;
      total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL x0_rdy got=%0h exp=1", dec_ready); end
      tick();
      total++; if (a_in !== 32'h0) begin bad++; $display("FAIL x0_a got=%0h exp=0", a_in); end
      total++; if (b_in !== 32'h0) begin bad++; $display("FAIL x0_b got=%0h exp=0", b_in); end
      idle(); tick();
   endtask

   task automatic test_opsel;
      issue(2, 3, 32'h11, 32'h33, 32'h22, 32'h400, 1, 1, 5'h01, 10, 1, 0);
      tick();
      total++; if (a_in !== 32'h400) begin bad++; $display("FAIL sel_pc got=%0h exp=400", a_in); end
      total++; if (b_in !== 32'h22) begin bad++; $display("FAIL sel_imm got=%0h exp=22", b_in); end
      total++; if (ALUControl !== 5'h01) begin bad++; $display("FAIL sel_alu got=%0h exp=1", ALUControl); end
      dec_opa_sel = 2; tick();
      total++; if (a_in !== 32'h0) begin bad++; $display("FAIL sel_zero got=%0h exp=0", a_in); end
      dec_opa_sel = 1; tick();
      dec_opa_sel = 3; tick();
      total++; if (a_in !== 32'h0) begin bad++; $display("FAIL sel_rsv got=%0h exp=0", a_in); end
      dec_opa_sel = 0; dec_opb_sel = 0; tick();
      total++; if (a_in !== 32'h11) begin bad++; $display("FAIL sel_rs1 got=%0h exp=11", a_in); end
      total++; if (b_in !== 32'h33) begin bad++; $display("FAIL sel_rs2 got=%0h exp=33", b_in); end
      total++; if (ex_rs2_val !== 32'h33) begin bad++; $display("FAIL sel_rs2v got=%0h exp=33", ex_rs2_val); end
      ex_result = 32'h55;
      issue(0, 10, 0, 32'h66, 8, 32'h410, 0, 1, 5'h00, 11, 1, 1); #1;
      total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL st_ld_rs2 got=%0h exp=1", dec_ready); end
      dec_reg_write = 0; dec_is_load = 0; #1;
`ifdef ID_EX_FWD_EN
      total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL st_rdy got=%0h exp=1", dec_ready); end
      tick();
      total++; if (b_in !== 32'h8) begin bad++; $display("FAIL st_b got=%0h exp=8", b_in); end
      total++; if (ex_rs2_val !== 32'h55) begin bad++; $display("FAIL st_rs2v got=%0h exp=55", ex_rs2_val); end
      total++; if (ex_reg_write !== 1'b0) begin bad++; $display("FAIL st_rw got=%0h exp=0", ex_reg_write); end
`else
      total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL st_stall got=%0h exp=0", dec_ready); end
`endif
      idle(); tick();
   endtask

   task automatic test_backpressure;
      issue(0, 0, 0, 0, 9, 32'h500, 1, 1, 5'h04, 11, 1, 0);
      tick();
      ex_ready = 0;
      issue(0, 0, 0, 0, 3, 32'h600, 1, 1, 5'h03, 12, 1, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL bp_rdy[%0d] got=%0h exp=0", i, dec_ready); end
         total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL bp_v[%0d] got=%0h exp=1", i, ex_valid); end
         total++; if (a_in !== 32'h500) begin bad++; $display("FAIL bp_a[%0d] got=%0h exp=500", i, a_in); end
         total++; if (b_in !== 32'h9) begin bad++; $display("FAIL bp_b[%0d] got=%0h exp=9", i, b_in); end
         total++; if (ALUControl !== 5'h04) begin bad++; $display("FAIL bp_alu[%0d] got=%0h exp=4", i, ALUControl); end
         total++; if (ex_rd !== 5'd11) begin bad++; $display("FAIL bp_rd[%0d] got=%0h exp=11", i, ex_rd); end
         tick();
      end
      ex_ready = 1; #1;
      total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0h exp=1", dec_ready); end
      tick();
      total++; if (a_in !== 32'h600) begin bad++; $display("FAIL bp_next_a got=%0h exp=600", a_in); end
      total++; if (ex_rd !== 5'd12) begin bad++; $display("FAIL bp_next_rd got=%0h exp=12", ex_rd); end
   endtask

   task automatic test_flush;
      flush = 1;
      issue(0, 0, 0, 0, 1, 32'h700, 1, 1, 5'h00, 13, 1, 0); #1;
      total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL fl_rdy got=%0h exp=0", dec_ready); end
      tick();
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL fl_v got=%0h exp=0", ex_valid); end
      flush = 0; tick();
      total++; if (ex_pc !== 32'h700) begin bad++; $display("FAIL fl_recap got=%0h exp=700", ex_pc); end
      ex_ready = 0; flush = 1; dec_valid = 0; tick();
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL fl_stalled got=%0h exp=0", ex_valid); end
      idle(); tick();
   endtask

   task automatic test_reset_mid_stall;
      issue(0, 0, 0, 0, 32'h40, 32'h800, 1, 1, 5'h09, 3, 1, 1);
      tick();
      total++; if (ALUControl !== 5'h09) begin bad++; $display("FAIL rms_pre_alu got=%0h exp=9", ALUControl); end
      issue(3, 0, 0, 0, 0, 32'h804, 0, 1, 5'h00, 4, 1, 0); #1;
      total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL rms_stall got=%0h exp=0", dec_ready); end
      #1 reset = 1; #1;
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rms_v got=%0h exp=0", ex_valid); end
      total++; if (ALUControl !== 5'h0) begin bad++; $display("FAIL rms_alu got=%0h exp=0", ALUControl); end
      total++; if (a_in !== 32'h0) begin bad++; $display("FAIL rms_a got=%0h exp=0", a_in); end
      total++; if (b_in !== 32'h0) begin bad++; $display("FAIL rms_b got=%0h exp=0", b_in); end
      total++; if (ex_is_load !== 1'b0) begin bad++; $display("FAIL rms_ld got=%0h exp=0", ex_is_load); end
      tick();
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rms_hold got=%0h exp=0", ex_valid); end
      reset = 0; idle(); tick();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_load_use();
      test_priority();
      test_x0();
      test_opsel();
      test_backpressure();
      test_flush();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
